// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis bank indices and trace-back source pairs
package viterbi_pkg;
  typedef logic [1:0] bank_t;
  localparam int N_BANKS = 4;
  localparam bank_t BANK_A = 2'd0;
  localparam bank_t BANK_B = 2'd1;
  localparam bank_t BANK_C = 2'd2;
  localparam bank_t BANK_D = 2'd3;
  localparam bank_t TBU0_SRC0_LO = BANK_D;
  localparam bank_t TBU0_SRC1_LO = BANK_C;
  localparam bank_t TBU0_SRC0_HI = BANK_B;
  localparam bank_t TBU0_SRC1_HI = BANK_A;
  localparam bank_t TBU1_SRC0_LO = BANK_C;
  localparam bank_t TBU1_SRC1_LO = BANK_B;
  localparam bank_t TBU1_SRC0_HI = BANK_A;
  localparam bank_t TBU1_SRC1_HI = BANK_D;
endpackage

// File: rtl/trellis_mem_sched_tbu_steer.sv
// tbu_steer: registered trace-back source/selector steering with sticky enables
module tbu_steer
  import viterbi_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  bank_t w2,
  output logic  tbu0_en,
  output logic  tbu1_en,
  output bank_t tbu0_src0,
  output bank_t tbu0_src1,
  output bank_t tbu1_src0,
  output bank_t tbu1_src1,
  output logic  tbu0_sel,
  output logic  tbu1_sel
);
  logic x;
  bank_t s00, s01, s10, s11;
  // source pairs decoded from the twice-delayed write bank
  always_comb begin
    x = w2[1] ^ w2[0];
    s00 = w2[1] ? TBU0_SRC0_HI : TBU0_SRC0_LO;
    s01 = w2[1] ? TBU0_SRC1_HI : TBU0_SRC1_LO;
    s10 = x ? TBU1_SRC0_HI : TBU1_SRC0_LO;
    s11 = x ? TBU1_SRC1_HI : TBU1_SRC1_LO;
  end
  // output register; enables latch once the trellis has filled far enough
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tbu0_en <= 1'b0;
      tbu1_en <= 1'b0;
      tbu0_src0 <= TBU0_SRC0_LO;
      tbu0_src1 <= TBU0_SRC1_LO;
      tbu1_src0 <= TBU1_SRC0_LO;
      tbu1_src1 <= TBU1_SRC1_LO;
      tbu0_sel <= 1'b0;
      tbu1_sel <= 1'b1;
    end else if (clr) begin
      tbu0_en <= 1'b0;
      tbu1_en <= 1'b0;
      tbu0_src0 <= TBU0_SRC0_LO;
      tbu0_src1 <= TBU0_SRC1_LO;
      tbu1_src0 <= TBU1_SRC0_LO;
      tbu1_src1 <= TBU1_SRC1_LO;
      tbu0_sel <= 1'b0;
      tbu1_sel <= 1'b1;
    end else begin
      tbu0_en <= tbu0_en | (w2 == BANK_C);
      tbu1_en <= tbu1_en | (w2 == BANK_D);
      tbu0_src0 <= s00;
      tbu0_src1 <= s01;
      tbu1_src0 <= s10;
      tbu1_src1 <= s11;
      tbu0_sel <= w2[0];
      tbu1_sel <= ~w2[0];
    end
endmodule

// File: rtl/trellis_mem_sched.sv
// trellis_mem_sched: four-bank survivor memory write rotation, addressing and TBU steering
module trellis_mem_sched
  import viterbi_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      sel_valid,
  output logic [N_BANKS-1:0]        wr_en,
  output logic [N_BANKS*ADDR_W-1:0] bank_addr,
  output bank_t                     wr_bank,
  output logic                      block_done,
  output logic                      tbu0_en,
  output logic                      tbu1_en,
  output bank_t                     tbu0_src0,
  output bank_t                     tbu0_src1,
  output bank_t                     tbu1_src0,
  output bank_t                     tbu1_src1,
  output logic                      tbu0_sel,
  output logic                      tbu1_sel
);
  logic [ADDR_W-1:0] wc, rc;
  logic [N_BANKS*ADDR_W-1:0] addr_d;
  logic wrap;
  bank_t d1, w2;
  assign rc = ~wc;
  assign wrap = sel_valid && (&wc);
  for (genvar i = 0; i < N_BANKS; i++) begin : g_addr
    bank_t r;
    assign r = bank_t'(i) - wr_bank;
    assign addr_d[i*ADDR_W +: ADDR_W] = r == 2'd0 ? wc : r == 2'd2 ? '0 : rc;
  end
  // counters, bank rotation, registered strobes/addresses and the w2 delay line
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wc <= '0;
      wr_bank <= BANK_A;
      block_done <= 1'b0;
      wr_en <= '0;
      bank_addr <= '0;
      d1 <= BANK_A;
      w2 <= BANK_A;
    end else if (!enable) begin
      wc <= '0;
      wr_bank <= BANK_A;
      block_done <= 1'b0;
      wr_en <= '0;
      bank_addr <= '0;
      d1 <= BANK_A;
      w2 <= BANK_A;
    end else begin
      wc <= wc + ADDR_W'(sel_valid);
      wr_bank <= wr_bank + bank_t'(wrap);
      block_done <= wrap;
      wr_en <= sel_valid ? N_BANKS'(1) << wr_bank : '0;
      bank_addr <= addr_d;
      d1 <= wr_bank;
      w2 <= d1;
    end
  tbu_steer u_steer (
    .clk       (clk),
    .rst       (rst),
    .clr       (!enable),
    .w2        (w2),
    .tbu0_en   (tbu0_en),
    .tbu1_en   (tbu1_en),
    .tbu0_src0 (tbu0_src0),
    .tbu0_src1 (tbu0_src1),
    .tbu1_src0 (tbu1_src0),
    .tbu1_src1 (tbu1_src1),
    .tbu0_sel  (tbu0_sel),
    .tbu1_sel  (tbu1_sel)
  );
endmodule

// File: tb/tb_trellis_mem_sched.sv
// tb_trellis_mem_sched: randomized self-checking bench against a counting reference model
module tb_trellis_mem_sched;
  logic clk = 0, rst = 0, enable = 0, sel_valid = 0;
  logic [3:0] wr_en;
  logic [15:0] bank_addr;
  logic [1:0] wr_bank, tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1;
  logic block_done, tbu0_en, tbu1_en, tbu0_sel, tbu1_sel;
  int checks = 0, errors = 0;
  int n;
  int hist[$];
  logic [3:0] m_wr_en;
  logic [15:0] m_addr;
  logic [1:0] m_bank, m_w3, m_s00, m_s01, m_s10, m_s11;
  logic m_done, e0, e1;

  trellis_mem_sched #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sel_valid(sel_valid),
    .wr_en(wr_en), .bank_addr(bank_addr), .wr_bank(wr_bank), .block_done(block_done),
    .tbu0_en(tbu0_en), .tbu1_en(tbu1_en),
    .tbu0_src0(tbu0_src0), .tbu0_src1(tbu0_src1), .tbu1_src0(tbu1_src0), .tbu1_src1(tbu1_src1),
    .tbu0_sel(tbu0_sel), .tbu1_sel(tbu1_sel)
  );

  always #5 clk = ~clk;

  task automatic model_tbu();
    m_w3 = 2'(hist[0]);
    e0 |= (m_w3 == 2'd2);
    e1 |= (m_w3 == 2'd3);
    m_s00 = m_w3[1] ? 2'd1 : 2'd3;
    m_s01 = m_w3[1] ? 2'd0 : 2'd2;
    m_s10 = (m_w3[1] ^ m_w3[0]) ? 2'd0 : 2'd2;
    m_s11 = (m_w3[1] ^ m_w3[0]) ? 2'd3 : 2'd1;
  endtask

  task automatic model_clear();
    n = 0;
    m_wr_en = '0;
    m_addr = '0;
    m_done = 0;
    m_bank = 0;
    e0 = 0;
    e1 = 0;
    hist = '{0, 0, 0, 0};
    model_tbu();
  endtask

  task automatic tick(input logic en, input logic sv);
    int wc0, wb0;
    enable = en;
    sel_valid = sv;
    @(posedge clk);
    wc0 = n % 16;
    wb0 = (n / 16) % 4;
    if (!en) model_clear();
    else begin
      m_wr_en = sv ? 4'(1 << wb0) : 4'd0;
      for (int i = 0; i < 4; i++)
        m_addr[i*4 +: 4] = i == wb0 ? 4'(wc0) : i == (wb0 + 2) % 4 ? 4'd0 : 4'(15 - wc0);
      m_done = sv && wc0 == 15;
      if (sv) n++;
      m_bank = 2'((n / 16) % 4);
      hist.push_back(int'(m_bank));
      void'(hist.pop_front());
      model_tbu();
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    enable = 0;
    sel_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (wr_en !== 4'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe wr_en=%b done=%b need 0000/0", wr_en, block_done);
    end
    checks++;
    if (bank_addr !== 16'd0 || wr_bank !== 2'd0) begin
      errors++;
      $display("FAIL reset_addr addr=%h bank=%0d need 0000/0", bank_addr, wr_bank);
    end
    checks++;
    if ({tbu0_en, tbu1_en, tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1, tbu0_sel, tbu1_sel} !== 12'b00_11_10_10_01_0_1) begin
      errors++;
      $display("FAIL reset_tbu got %b%b %0d%0d %0d%0d %b%b need 00 32 21 01", tbu0_en, tbu1_en,
               tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1, tbu0_sel, tbu1_sel);
    end
  endtask

  task automatic test_first_block();
    do_reset();
    tick(1, 1);
    checks++;
    if (wr_en !== 4'b0001 || bank_addr !== 16'hF0F0) begin
      errors++;
      $display("FAIL first_accept wr_en=%b addr=%h need 0001/f0f0", wr_en, bank_addr);
    end
    repeat (14) tick(1, 1);
    checks++;
    if (block_done !== 1'b0 || wr_bank !== 2'd0) begin
      errors++;
      $display("FAIL pre_wrap done=%b bank=%0d need 0/0", block_done, wr_bank);
    end
    tick(1, 1);
    checks++;
    if (block_done !== 1'b1 || wr_bank !== 2'd1) begin
      errors++;
      $display("FAIL wrap done=%b bank=%0d need 1/1", block_done, wr_bank);
    end
    tick(1, 1);
    checks++;
    if (block_done !== 1'b0 || wr_en !== 4'b0010) begin
      errors++;
      $display("FAIL post_wrap done=%b wr_en=%b need 0/0010", block_done, wr_en);
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) tick(1, 1);
    for (int k = 0; k < 2; k++) begin
      tick(1, 0);
      checks++;
      if (wr_en !== 4'd0 || bank_addr[3:0] !== 4'd3 || bank_addr[7:4] !== 4'd12) begin
        errors++;
        $display("FAIL stall%0d wr_en=%b addrA=%0d addrB=%0d need 0000/3/12", k, wr_en, bank_addr[3:0], bank_addr[7:4]);
      end
    end
    tick(1, 1);
    checks++;
    if (wr_en !== 4'b0001 || bank_addr[3:0] !== 4'd3) begin
      errors++;
      $display("FAIL resume wr_en=%b addrA=%0d need 0001/3", wr_en, bank_addr[3:0]);
    end
    tick(1, 0);
    checks++;
    if (bank_addr[3:0] !== 4'd4 || wr_en !== 4'd0) begin
      errors++;
      $display("FAIL advance addrA=%0d wr_en=%b need 4/0000", bank_addr[3:0], wr_en);
    end
  endtask

  task automatic test_tbu();
    int cyc, b2, b3, r0, r1;
    do_reset();
    b2 = -1; b3 = -1; r0 = -1; r1 = -1;
    for (cyc = 0; cyc < 68; cyc++) begin
      tick(1, 1);
      if (wr_bank === 2'd2 && b2 < 0) b2 = cyc;
      if (wr_bank === 2'd3 && b3 < 0) b3 = cyc;
      if (tbu0_en === 1'b1 && r0 < 0) r0 = cyc;
      if (tbu1_en === 1'b1 && r1 < 0) r1 = cyc;
      checks++;
      if ({tbu0_en, tbu1_en, tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1, tbu0_sel, tbu1_sel} !==
          {e0, e1, m_s00, m_s01, m_s10, m_s11, m_w3[0], ~m_w3[0]}) begin
        errors++;
        $display("FAIL tbu_cyc%0d got %b%b %0d%0d %0d%0d %b%b need %b%b %0d%0d %0d%0d %b%b", cyc,
                 tbu0_en, tbu1_en, tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1, tbu0_sel, tbu1_sel,
                 e0, e1, m_s00, m_s01, m_s10, m_s11, m_w3[0], ~m_w3[0]);
      end
      if (cyc == 34) begin
        checks++;
        if ({tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1, tbu0_sel, tbu1_sel} !== 10'b01_00_00_11_0_1) begin
          errors++;
          $display("FAIL w2_is_2 got %0d%0d %0d%0d %b%b need 10 03 01", tbu0_src0, tbu0_src1,
                   tbu1_src0, tbu1_src1, tbu0_sel, tbu1_sel);
        end
      end
      if (cyc == 63) begin
        checks++;
        if (wr_bank !== 2'd0 || block_done !== 1'b1) begin
          errors++;
          $display("FAIL rotate_back bank=%0d done=%b need 0/1", wr_bank, block_done);
        end
      end
      if (cyc == 64) begin
        checks++;
        if (bank_addr[11:8] !== 4'd0 || bank_addr[3:0] !== 4'd0 || tbu0_en !== 1'b1 || tbu1_en !== 1'b1) begin
          errors++;
          $display("FAIL idle_c addrC=%0d addrA=%0d en=%b%b need 0/0/11", bank_addr[11:8], bank_addr[3:0], tbu0_en, tbu1_en);
        end
      end
    end
    checks++;
    if (r0 - b2 !== 3 || r1 - b3 !== 3) begin
      errors++;
      $display("FAIL tbu_lag en0_lag=%0d en1_lag=%0d need 3/3", r0 - b2, r1 - b3);
    end
  endtask

  task automatic test_restart();
    do_reset();
    repeat (23) tick(1, 1);
    checks++;
    if (wr_bank !== 2'd1 || bank_addr[7:4] !== 4'd6) begin
      errors++;
      $display("FAIL mid_block bank=%0d addrB=%0d need 1/6", wr_bank, bank_addr[7:4]);
    end
    tick(0, 1);
    checks++;
    if (wr_en !== 4'd0 || bank_addr !== 16'd0 || wr_bank !== 2'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL restart wr_en=%b addr=%h bank=%0d done=%b need 0000/0000/0/0", wr_en, bank_addr, wr_bank, block_done);
    end
    tick(1, 1);
    checks++;
    if (wr_en !== 4'b0001 || bank_addr[3:0] !== 4'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_resume wr_en=%b addrA=%0d done=%b need 0001/0/0", wr_en, bank_addr[3:0], block_done);
    end
    repeat (14) tick(1, 1);
    tick(0, 1);
    checks++;
    if (wr_bank !== 2'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_vs_restart bank=%0d done=%b need 0/0", wr_bank, block_done);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (20) tick(1, 1);
    checks++;
    if (wr_en !== 4'b0010) begin
      errors++;
      $display("FAIL pre_async wr_en=%b need 0010", wr_en);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if (wr_en !== 4'd0 || bank_addr !== 16'd0 || wr_bank !== 2'd0) begin
      errors++;
      $display("FAIL async_rst wr_en=%b addr=%h bank=%0d need 0000/0000/0", wr_en, bank_addr, wr_bank);
    end
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  task automatic test_random();
    logic [34:0] got, exp;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      tick($urandom_range(99) != 0, $urandom_range(3) != 0);
      got = {wr_en, bank_addr, wr_bank, block_done, tbu0_en, tbu1_en,
             tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1, tbu0_sel, tbu1_sel};
      exp = {m_wr_en, m_addr, m_bank, m_done, e0, e1, m_s00, m_s01, m_s10, m_s11, m_w3[0], ~m_w3[0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random%0d got %h need %h", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_block();
    test_stall();
    test_tbu();
    test_restart();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
